busdebugger_command: RTL and testbench

//  Command decoder on the serial receive path of the bus debugger. Consumes bytes from usart_rx,

---
 rtl/busdebugger_command.sv | 233 +++++++++++++++++++++++
 tb/tb_busdebugger_command.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busdebugger_command.sv
// Bus debugger command decoder: parses rx bytes into snooper/dumper
// control strobes and returns one status byte per command.
module busdebugger_command #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESET_CYCLES   = 16
) (
  input  logic        comm_clock,
  input  logic        reset,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_data,
  output logic        dump_start,
  output logic        record_start,
  output logic        record_trigger,
  output logic        soft_reset,
  output logic [31:0] trigger_addr,
  output logic        trigger_enable,
  output logic        busy
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_BAD = 8'h3F;
  localparam logic [7:0] ST_ERR = 8'h21;
  localparam logic [7:0] ST_TMO = 8'h54;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARG,
    S_RESP,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   arg_q, arg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] hold_q, hold_d;
  logic [7:0]    resp_q, resp_d;
  logic          dump_q, dump_d;
  logic          rec_q, rec_d;
  logic          trig_q, trig_d;
  logic          ten_q, ten_d;
  logic [31:0]   taddr_q, taddr_d;

  logic       accept;
  logic       is_hex;
  logic [3:0] nib;

  assign rx_ready = reset &
    ((state_q == S_IDLE) | (state_q == S_ARG));
  assign accept = rx_valid & rx_ready;

  // Letters map to 10..15 via their low nibble (a/A = 1) + 9.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    unique case (1'b1)
      (rx_data >= 8'h30) && (rx_data <= 8'h39): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0];
      end
      (rx_data >= 8'h61) && (rx_data <= 8'h66),
      (rx_data >= 8'h41) && (rx_data <= 8'h46): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      default: begin
        is_hex = 1'b0;
        nib    = 4'h0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    resp_d  = resp_q;
    dump_d  = 1'b0;
    rec_d   = 1'b0;
    trig_d  = 1'b0;
    ten_d   = ten_q;
    taddr_d = taddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rx_error) begin
            state_d = S_RESP;
            resp_d  = ST_ERR;
          end else begin
            case (rx_data)
              8'h64: begin
                dump_d  = 1'b1;
                state_d = S_RESP;
                resp_d  = ST_OK;
              end
              8'h72: begin
                rec_d   = 1'b1;
                state_d = S_RESP;
                resp_d  = ST_OK;
              end
              8'h74: begin
                trig_d  = 1'b1;
                state_d = S_RESP;
                resp_d  = ST_OK;
              end
              8'h65, 8'h6E: begin
                ten_d   = (rx_data == 8'h65);
                state_d = S_RESP;
                resp_d  = ST_OK;
              end
              8'h61: begin
                state_d = S_ARG;
                arg_d   = 32'h0;
                cnt_d   = 4'd0;
                tmo_d   = '0;
              end
              8'h78: begin
                state_d = S_HOLD;
                hold_d  = '0;
                resp_d  = ST_OK;
              end
              8'h20, 8'h0A, CH_CR: begin
                state_d = S_IDLE;
              end
              default: begin
                state_d = S_RESP;
                resp_d  = ST_BAD;
              end
            endcase
          end
        end
      end
      S_ARG: begin
        if (accept) begin
          tmo_d = '0;
          if (rx_error) begin
            state_d = S_RESP;
            resp_d  = ST_ERR;
            arg_d   = 32'h0;
            cnt_d   = 4'd0;
          end else if (is_hex && cnt_q != 4'd8) begin
            arg_d = {arg_q[27:0], nib};
            cnt_d = cnt_q + 4'd1;
          end else if (rx_data == CH_CR && cnt_q != 4'd0
                       && !is_hex) begin
            taddr_d = arg_q;
            state_d = S_RESP;
            resp_d  = ST_OK;
          end else begin
            state_d = S_RESP;
            resp_d  = ST_BAD;
            arg_d   = 32'h0;
            cnt_d   = 4'd0;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_RESP;
          resp_d  = ST_TMO;
          arg_d   = 32'h0;
          cnt_d   = 4'd0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (hold_q == RST_LAST) begin
          state_d = S_RESP;
        end else begin
          hold_d = hold_q + RW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      arg_q   <= 32'h0;
      cnt_q   <= 4'd0;
      tmo_q   <= '0;
      hold_q  <= '0;
      resp_q  <= 8'h0;
      dump_q  <= 1'b0;
      rec_q   <= 1'b0;
      trig_q  <= 1'b0;
      ten_q   <= 1'b0;
      taddr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      resp_q  <= resp_d;
      dump_q  <= dump_d;
      rec_q   <= rec_d;
      trig_q  <= trig_d;
      ten_q   <= ten_d;
      taddr_q <= taddr_d;
    end
  end

  assign resp_valid     = (state_q == S_RESP);
  assign resp_data      = resp_valid ? resp_q : 8'h0;
  assign soft_reset     = (state_q == S_HOLD);
  assign busy           = (state_q != S_IDLE);
  assign dump_start     = dump_q;
  assign record_start   = rec_q;
  assign record_trigger = trig_q;
  assign trigger_addr   = taddr_q;
  assign trigger_enable = ten_q;

endmodule

// File: tb/tb_busdebugger_command.sv
// Randomized self-checking bench for busdebugger_command against
// a byte-sequence reference model of the command language.
module tb_busdebugger_command;

  localparam int TMO = 50;
  localparam int RC  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_error = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic        dump_start;
  logic        record_start;
  logic        record_trigger;
  logic        soft_reset;
  logic [31:0] trigger_addr;
  logic        trigger_enable;
  logic        busy;

  busdebugger_command #(
    .TIMEOUT_CYCLES(TMO),
    .RESET_CYCLES  (RC)
  ) dut (
    .comm_clock    (clk),
    .reset         (rst_n),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_error      (rx_error),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .dump_start    (dump_start),
    .record_start  (record_start),
    .record_trigger(record_trigger),
    .soft_reset    (soft_reset),
    .trigger_addr  (trigger_addr),
    .trigger_enable(trigger_enable),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_taddr = 32'h0;
  logic        m_ten   = 1'b0;
  logic [7:0]  e_resp;
  logic        e_dump, e_rec, e_trig, e_x;

  logic [7:0] txb[32];
  bit         txe[32];
  int         txn;

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return -1;
  endfunction

  task automatic push(input logic [7:0] b, input bit e);
    txb[txn] = b;
    txe[txn] = e;
    txn++;
  endtask

  task automatic load(input string s);
    txn = 0;
    for (int i = 0; i < s.len(); i++) push(s[i], 1'b0);
  endtask

  // Walks the byte list until the first byte that yields a status.
  task automatic model(output int last);
    bit          in_arg;
    int          cnt;
    int          v;
    logic [31:0] a;
    logic [7:0]  b;
    in_arg = 0; cnt = 0; a = 0; last = -1;
    e_resp = 0; e_dump = 0; e_rec = 0; e_trig = 0; e_x = 0;
    for (int i = 0; i < txn && last < 0; i++) begin
      b = txb[i];
      if (txe[i]) begin
        e_resp = "!"; last = i;
      end else if (!in_arg) begin
        case (b)
          "d": begin e_dump = 1; e_resp = "K"; last = i; end
          "r": begin e_rec = 1; e_resp = "K"; last = i; end
          "t": begin e_trig = 1; e_resp = "K"; last = i; end
          "e": begin m_ten = 1; e_resp = "K"; last = i; end
          "n": begin m_ten = 0; e_resp = "K"; last = i; end
          "x": begin e_x = 1; e_resp = "K"; last = i; end
          "a": begin in_arg = 1; cnt = 0; a = 0; end
          " ", 8'h0A, 8'h0D: ;
          default: begin e_resp = "?"; last = i; end
        endcase
      end else begin
        v = hexval(b);
        if (v >= 0) begin
          if (cnt == 8) begin
            e_resp = "?"; last = i;
          end else begin
            a = a * 16 + v; cnt++;
          end
        end else if (b == 8'h0D && cnt > 0) begin
          m_taddr = a; e_resp = "K"; last = i;
        end else begin
          e_resp = "?"; last = i;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", {31'h0, rx_ready}, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_error = e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic finish_resp(input int dly);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, e_resp);
      chk("bp_rx_ready", rx_ready, 0);
      chk("strobe_width",
          {dump_start, record_start, record_trigger}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", resp_valid, 0);
  endtask

  task automatic run_txn(input int dly);
    int last;
    model(last);
    if (last < 0) return;
    for (int i = 0; i <= last; i++) send_byte(txb[i], txe[i]);
    @(negedge clk);
    if (e_x) begin
      for (int k = 0; k < RC; k++) begin
        chk("srst_on", soft_reset, 1);
        chk("srst_no_resp", resp_valid, 0);
        @(negedge clk);
      end
      chk("srst_off", soft_reset, 0);
    end else begin
      chk("dump_start", dump_start, e_dump);
      chk("record_start", record_start, e_rec);
      chk("record_trigger", record_trigger, e_trig);
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, e_resp);
    chk("trigger_addr", trigger_addr, m_taddr);
    chk("trigger_enable", trigger_enable, m_ten);
    finish_resp(dly);
  endtask

  task automatic gen();
    string ws  = " \n\r";
    string hx  = "0123456789abcdefABCDEF";
    string bad = "qz19A#";
    string nh  = "gz .";
    int    k;
    txn = 0;
    repeat ($urandom_range(0, 2)) push(ws[$urandom_range(0, 2)], 0);
    k = $urandom_range(0, 9);
    case (k)
      0: push("d", 0);
      1: push("r", 0);
      2: push("t", 0);
      3: push("e", 0);
      4: push("n", 0);
      5: push("x", 0);
      6: push(bad[$urandom_range(0, 5)], 0);
      default: begin
        push("a", 0);
        repeat ($urandom_range(0, 9)) push(hx[$urandom_range(0, 21)], 0);
        if ($urandom_range(0, 3) == 0) push(nh[$urandom_range(0, 3)], 0);
        else push(8'h0D, 0);
      end
    endcase
    if ($urandom_range(0, 7) == 0) txe[$urandom_range(0, txn - 1)] = 1;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_strobes",
        {dump_start, record_start, record_trigger, soft_reset}, 0);
    chk("rst_taddr", trigger_addr, 0);
    chk("rst_ten", trigger_enable, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    load("d"); run_txn(0);
    load("a12aB00Ff"); push(8'h0D, 0); run_txn(1);
    chk("addr_12ab00ff", trigger_addr, 32'h12AB00FF);
    load("a5"); push(8'h0D, 0); run_txn(0);
    chk("addr_5", trigger_addr, 32'h5);
    load("a123456789"); run_txn(0);
    chk("addr_9dig_kept", trigger_addr, 32'h5);
    load("a"); push(8'h0D, 0); run_txn(2);
    load("x"); run_txn(0);
    load("q"); run_txn(10);
    load("r"); run_txn(0);
    load("e"); run_txn(0);
    load("n"); run_txn(0);
    load("d"); txe[0] = 1; run_txn(0);

    send_byte(" ", 0);
    @(negedge clk);
    chk("ws_busy", busy, 0);
    chk("ws_valid", resp_valid, 0);

    send_byte("a", 0);
    send_byte("1", 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 200);
    chk("tmo_latency", n, TMO + 1);
    e_resp = "T";
    chk("tmo_data", resp_data, e_resp);
    chk("tmo_addr_kept", trigger_addr, m_taddr);
    finish_resp(0);

    for (int i = 0; i < 80; i++) begin
      gen();
      run_txn($urandom_range(0, 3));
    end

    load("e"); run_txn(0);
    send_byte("a", 0);
    send_byte("1", 0);
    @(negedge clk);
    chk("arg_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_ten", trigger_enable, 0);
    chk("mid_rst_taddr", trigger_addr, 0);
    chk("mid_rst_valid", resp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_taddr = 32'h0;
    m_ten   = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    load("t"); run_txn(1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
